// File: rtl/rggen_rtl_pkg.sv
// Package shared by the APB register bridge and its response mux.
//  - rggen_status:        response status carried back from each register slot.
//  - rggen_bridge_state:  bridge FSM states.
//  - rggen_counter_width: width of the stall counter for a given timeout.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'd0,
        RGGEN_EXOKAY       = 2'd1,
        RGGEN_SLAVE_ERROR  = 2'd2,
        RGGEN_DECODE_ERROR = 2'd3
    } rggen_status;

    typedef enum logic [1:0] {
        BRIDGE_IDLE     = 2'd0,
        BRIDGE_REQUEST  = 2'd1,
        BRIDGE_RESPONSE = 2'd2
    } rggen_bridge_state;

    // The counter must hold values up to TIMEOUT_CYCLES; a zero timeout
    // still gets a one-bit counter so no zero-width vector is ever declared.
    function automatic int rggen_counter_width(input int timeout_cycles);
        if (timeout_cycles < 1) begin
            return 1;
        end
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/rggen_response_mux.sv
// One-hot OR reduction of the per-register response signals.
// Ports:
//  i_ready     per-slot ready
//  i_status    per-slot 2-bit status, slot n at [2n+1:2n]
//  i_read_data per-slot read data, slot n at [DATA_WIDTH*n +: DATA_WIDTH]
//  o_ready     any slot ready
//  o_status    OR of the status of every ready slot
//  o_read_data OR of the read data of every ready slot
module rggen_response_mux #(
    parameter int REGISTERS  = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic [REGISTERS-1:0]            i_ready,
    input  logic [2*REGISTERS-1:0]          i_status,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data,
    output logic                            o_ready,
    output logic [1:0]                      o_status,
    output logic [DATA_WIDTH-1:0]           o_read_data
);

    logic [1:0]            w_status_masked [REGISTERS];
    logic [DATA_WIDTH-1:0] w_data_masked   [REGISTERS];

    // Slots that are not ready contribute nothing to the reduction, so
    // whatever they drive on their status/data lines is don't-care.
    genvar gi;
    generate
        for (gi = 0; gi < REGISTERS; gi++) begin : g_slot
            assign w_status_masked[gi] = i_status[2*gi +: 2] & {2{i_ready[gi]}};
            assign w_data_masked[gi]   = i_read_data[DATA_WIDTH*gi +: DATA_WIDTH]
                                       & {DATA_WIDTH{i_ready[gi]}};
        end
    endgenerate

    always_comb begin
        o_status    = '0;
        o_read_data = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            o_status    = o_status    | w_status_masked[i];
            o_read_data = o_read_data | w_data_masked[i];
        end
    end

    assign o_ready = |i_ready;

endmodule

// File: rtl/rggen_apb_register_bridge.sv
// APB4 slave front end for a register block. Each APB transfer becomes one
// request on the flattened register bus; the bridge waits for a selected
// register's ready (or a decode miss / stall timeout) and then returns a
// one-cycle PREADY with PRDATA/PSLVERR.
// Ports:
//  clk, rst_n                    clock, synchronous active-low reset
//  i_psel/i_penable/i_paddr/
//  i_pwrite/i_pwdata/i_pstrb     APB request side
//  o_pready/o_prdata/o_pslverr   APB response side
//  o_request/o_address/o_write/
//  o_write_data/o_write_mask     register bus request (latched at setup)
//  i_select/i_ready/i_status/
//  i_read_data                   per-register response side
module rggen_apb_register_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_psel,
    input  logic                            i_penable,
    input  logic [ADDRESS_WIDTH-1:0]        i_paddr,
    input  logic                            i_pwrite,
    input  logic [DATA_WIDTH-1:0]           i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]         i_pstrb,
    output logic                            o_pready,
    output logic [DATA_WIDTH-1:0]           o_prdata,
    output logic                            o_pslverr,
    output logic                            o_request,
    output logic [ADDRESS_WIDTH-1:0]        o_address,
    output logic                            o_write,
    output logic [DATA_WIDTH-1:0]           o_write_data,
    output logic [DATA_WIDTH-1:0]           o_write_mask,
    input  logic [REGISTERS-1:0]            i_select,
    input  logic [REGISTERS-1:0]            i_ready,
    input  logic [2*REGISTERS-1:0]          i_status,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data
);

    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int COUNT_WIDTH = rggen_counter_width(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    rggen_bridge_state        r_state;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic                     r_write;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic [DATA_WIDTH-1:0]    r_write_mask;
    rggen_status              r_status;
    logic [DATA_WIDTH-1:0]    r_read_data;
    logic [COUNT_WIDTH-1:0]   r_count;

    logic                     w_setup;
    logic                     w_timeout;
    logic [DATA_WIDTH-1:0]    w_write_mask;
    logic                     w_ready;
    logic [1:0]               w_status;
    logic [DATA_WIDTH-1:0]    w_read_data;

    // A setup phase is PSEL without PENABLE; only honoured while idle.
    assign w_setup = i_psel & ~i_penable;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_mask
            assign w_write_mask[8*gi +: 8] = {8{i_pstrb[gi]}};
        end
    endgenerate

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign w_timeout = 1'b0;
        end else begin : g_timeout
            localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST =
                COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
            // Counter reads k during the (k+1)-th REQUEST cycle, so this fires
            // on the last permitted cycle of waiting.
            assign w_timeout = (r_count == TIMEOUT_LAST);
        end
    endgenerate

    rggen_response_mux #(
        .REGISTERS  (REGISTERS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_response_mux (
        .i_ready     (i_ready),
        .i_status    (i_status),
        .i_read_data (i_read_data),
        .o_ready     (w_ready),
        .o_status    (w_status),
        .o_read_data (w_read_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= BRIDGE_IDLE;
            r_address    <= '0;
            r_write      <= 1'b0;
            r_write_data <= '0;
            r_write_mask <= '0;
            r_status     <= RGGEN_OKAY;
            r_read_data  <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                BRIDGE_IDLE: begin
                    if (w_setup) begin
                        r_address    <= i_paddr;
                        r_write      <= i_pwrite;
                        r_write_data <= i_pwdata;
                        r_write_mask <= w_write_mask;
                        r_state      <= BRIDGE_REQUEST;
                    end
                end
                BRIDGE_REQUEST: begin
                    if (!i_psel) begin
                        // Master abandoned the transfer: no response is owed.
                        r_count <= '0;
                        r_state <= BRIDGE_IDLE;
                    end else if (w_ready) begin
                        r_status    <= rggen_status'(w_status);
                        r_read_data <= w_read_data;
                        r_count     <= '0;
                        r_state     <= BRIDGE_RESPONSE;
                    end else if (~|i_select) begin
                        r_status    <= RGGEN_DECODE_ERROR;
                        r_read_data <= '0;
                        r_count     <= '0;
                        r_state     <= BRIDGE_RESPONSE;
                    end else if (w_timeout) begin
                        r_status    <= RGGEN_SLAVE_ERROR;
                        r_read_data <= '0;
                        r_count     <= '0;
                        r_state     <= BRIDGE_RESPONSE;
                    end else if (r_count != COUNT_MAX) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                BRIDGE_RESPONSE: begin
                    r_state <= BRIDGE_IDLE;
                end
                default: begin
                    r_state <= BRIDGE_IDLE;
                end
            endcase
        end
    end

    assign o_request    = (r_state == BRIDGE_REQUEST);
    assign o_pready     = (r_state == BRIDGE_RESPONSE);
    assign o_pslverr    = o_pready & ((r_status == RGGEN_SLAVE_ERROR) ||
                                      (r_status == RGGEN_DECODE_ERROR));
    // Write responses never carry data back, whatever the register drove.
    assign o_prdata     = (o_pready && !r_write) ? r_read_data : '0;
    assign o_address    = r_address;
    assign o_write      = r_write;
    assign o_write_data = r_write_data;
    assign o_write_mask = r_write_mask;

`ifndef SYNTHESIS
    // Overlapping address decode in the register block shows up here.
    a_single_ready: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_state == BRIDGE_REQUEST) |-> $onehot0(i_ready)
    );
`endif

endmodule

// File: tb/tb_rggen_apb_register_bridge.sv
module tb_rggen_apb_register_bridge;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int REGS = 4;
    localparam int TO   = 4;

    // Transfer kinds understood by the model
    localparam int K_NORMAL  = 0;  // selected slot answers after lat cycles
    localparam int K_DECODE  = 1;  // nothing selected
    localparam int K_TIMEOUT = 2;  // selected but never ready
    localparam int K_ABORT   = 3;  // psel dropped in request cycle lat

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 psel, penable, pwrite;
    logic [AW-1:0]        paddr;
    logic [DW-1:0]        pwdata;
    logic [DW/8-1:0]      pstrb;
    logic                 pready, pslverr, request, write;
    logic [DW-1:0]        prdata, write_data, write_mask;
    logic [AW-1:0]        address;
    logic [REGS-1:0]      select, ready;
    logic [2*REGS-1:0]    status;
    logic [REGS*DW-1:0]   read_data;

    rggen_apb_register_bridge #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .REGISTERS      (REGS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_psel       (psel),
        .i_penable    (penable),
        .i_paddr      (paddr),
        .i_pwrite     (pwrite),
        .i_pwdata     (pwdata),
        .i_pstrb      (pstrb),
        .o_pready     (pready),
        .o_prdata     (prdata),
        .o_pslverr    (pslverr),
        .o_request    (request),
        .o_address    (address),
        .o_write      (write),
        .o_write_data (write_data),
        .o_write_mask (write_mask),
        .i_select     (select),
        .i_ready      (ready),
        .i_status     (status),
        .i_read_data  (read_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle expectations produced by the transfer-level model
    logic          exp_valid = 1'b0;
    logic          exp_request, exp_pready, exp_pslverr, exp_fields, exp_write;
    logic [DW-1:0] exp_prdata, exp_write_data, exp_write_mask;
    logic [AW-1:0] exp_address;

    // Observations of the most recent transfer, used by literal checks
    int            obs_off;
    logic [DW-1:0] obs_prdata, obs_mask;
    logic          obs_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] strobe_to_mask(input logic [DW/8-1:0] s);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < DW/8; b++) begin
            if (s[b]) m = m | (32'hFF << (8 * b));
        end
        return m;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            check("request", 32'(request), 32'(exp_request));
            check("pready",  32'(pready),  32'(exp_pready));
            check("pslverr", 32'(pslverr), 32'(exp_pslverr));
            check("prdata",  prdata,       exp_prdata);
            if (exp_fields) begin
                check("address",    32'(address), 32'(exp_address));
                check("write",      32'(write),   32'(exp_write));
                check("write_data", write_data,   exp_write_data);
                check("write_mask", write_mask,   exp_write_mask);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_noise();
        select    = 4'($urandom);
        ready     = 4'($urandom);
        status    = 8'($urandom);
        read_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic exp_quiet();
        exp_request = 1'b0;
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        exp_prdata  = '0;
        exp_fields  = 1'b0;
    endtask

    task automatic observe(input int c);
        if (pready && obs_off < 0) begin
            obs_off    = c;
            obs_prdata = prdata;
            obs_err    = pslverr;
        end
        if (request) obs_mask = write_mask;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            next_cycle();
            psel    = 1'b0;
            penable = 1'b0;
            reg_noise();
            exp_quiet();
        end
    endtask

    // One APB transfer. Cycle 0 is setup; the bridge then spends n cycles in
    // request, and (unless aborted) answers in cycle n+1.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                        input logic [DW/8-1:0] st, input int kind, input int lat,
                        input int slot, input logic [DW-1:0] rd, input logic [1:0] stat,
                        input logic odd_setup);
        int n;
        obs_off    = -1;
        obs_prdata = '0;
        obs_err    = 1'b0;
        obs_mask   = '0;
        case (kind)
            K_NORMAL:  n = lat + 1;
            K_DECODE:  n = 1;
            K_TIMEOUT: n = TO;
            default:   n = lat + 1;
        endcase

        next_cycle();
        observe(0);
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wd;
        pstrb   = st;
        reg_noise();
        exp_quiet();

        for (int i = 0; i < n; i++) begin
            next_cycle();
            observe(i + 1);
            psel      = !(kind == K_ABORT && i == lat);
            penable   = 1'b1;
            status    = 8'($urandom);
            read_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            ready     = '0;
            select    = (kind == K_DECODE) ? 4'b0000 : ((4'b0001 << slot) | 4'($urandom));
            if (kind == K_NORMAL && i == lat) begin
                ready                    = 4'b0001 << slot;
                status[2*slot +: 2]      = stat;
                read_data[DW*slot +: DW] = rd;
            end
            exp_quiet();
            exp_request    = 1'b1;
            exp_fields     = 1'b1;
            exp_address    = addr;
            exp_write      = wr;
            exp_write_data = wd;
            exp_write_mask = strobe_to_mask(st);
        end

        if (kind != K_ABORT) begin
            next_cycle();
            observe(n + 1);
            psel    = 1'b1;
            penable = !odd_setup;
            reg_noise();
            exp_quiet();
            exp_pready  = 1'b1;
            exp_pslverr = (kind == K_NORMAL) ? stat[1] : 1'b1;
            exp_prdata  = (wr || kind != K_NORMAL) ? '0 : rd;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        paddr     = '0;
        pwrite    = 1'b0;
        pwdata    = '0;
        pstrb     = '0;
        select    = '0;
        ready     = '0;
        status    = '0;
        read_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_pready",  32'(pready),  32'h0);
        check("reset_request", 32'(request), 32'h0);
        check("reset_pslverr", 32'(pslverr), 32'h0);
        check("reset_prdata",  prdata,       32'h0);
        check("reset_address", 32'(address), 32'h0);
        exp_quiet();
        exp_valid = 1'b1;
        rst_n     = 1'b1;

        // Write with low half strobes, answered immediately by slot 1
        xfer(16'h0004, 1'b1, 32'hA5A5_0001, 4'b0011, K_NORMAL, 0, 1, 32'hDEAD_BEEF, 2'd0, 1'b0);
        check("wr_mask",    obs_mask,       32'h0000_FFFF);
        check("wr_latency", 32'(obs_off),   32'd2);
        check("wr_pslverr", 32'(obs_err),   32'd0);
        check("wr_prdata",  obs_prdata,     32'h0);

        // Read answered by slot 2 after three request cycles
        xfer(16'h0008, 1'b0, 32'h0, 4'hF, K_NORMAL, 2, 2, 32'h1234_5678, 2'd0, 1'b0);
        check("rd_latency", 32'(obs_off), 32'd4);
        check("rd_prdata",  obs_prdata,   32'h1234_5678);
        check("rd_pslverr", 32'(obs_err), 32'd0);

        // Unmapped address
        xfer(16'h00F0, 1'b0, 32'h0, 4'hF, K_DECODE, 0, 0, 32'h0, 2'd0, 1'b0);
        check("dec_latency", 32'(obs_off), 32'd2);
        check("dec_pslverr", 32'(obs_err), 32'd1);
        check("dec_prdata",  obs_prdata,   32'h0);

        // Stalled register: request entered at cycle 1, pready four cycles later
        idle(1);
        xfer(16'h0020, 1'b0, 32'h0, 4'hF, K_TIMEOUT, 0, 0, 32'h0, 2'd0, 1'b0);
        check("to_latency", 32'(obs_off), 32'd5);
        check("to_pslverr", 32'(obs_err), 32'd1);

        // Master abort in the second request cycle, then a normal transfer
        xfer(16'h000C, 1'b0, 32'h0, 4'hF, K_ABORT, 1, 0, 32'h0, 2'd0, 1'b0);
        check("abort_no_pready", 32'(obs_off), 32'hFFFF_FFFF);
        xfer(16'h000C, 1'b0, 32'h0, 4'hF, K_NORMAL, 0, 3, 32'hCAFE_F00D, 2'd1, 1'b0);
        check("post_abort_latency", 32'(obs_off), 32'd2);
        check("post_abort_prdata",  obs_prdata,   32'hCAFE_F00D);

        // Reset asserted while a request is pending
        next_cycle();
        psel = 1'b1; penable = 1'b0; paddr = 16'h0010; pwrite = 1'b1;
        pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        reg_noise();
        exp_quiet();
        next_cycle();
        penable = 1'b1; select = 4'b0001; ready = '0;
        exp_quiet();
        exp_request = 1'b1; exp_fields = 1'b1; exp_address = 16'h0010; exp_write = 1'b1;
        exp_write_data = 32'h5555_AAAA; exp_write_mask = 32'hFFFF_FFFF;
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
        exp_quiet();
        exp_fields = 1'b1; exp_address = '0; exp_write = 1'b0;
        exp_write_data = '0; exp_write_mask = '0;
        idle(1);

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            int            kind, lat;
            logic [DW-1:0] wd, rd;
            kind = $urandom_range(0, 9);
            if (kind < 6)       kind = K_NORMAL;
            else if (kind < 7)  kind = K_DECODE;
            else if (kind < 8)  kind = K_TIMEOUT;
            else                kind = K_ABORT;
            lat = $urandom_range(0, TO - 1);
            wd  = $urandom();
            rd  = $urandom();
            xfer(16'($urandom), 1'($urandom), wd, 4'($urandom), kind, lat,
                 $urandom_range(0, REGS - 1), rd, 2'($urandom), ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end

        idle(2);
        exp_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
